// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants, helpers and types for the FIFO read-side packer.
//   lane_w()          : width of the lane index for a given lanes-per-beat count
//   keep_from_count() : lane-valid mask with the low 'count' bits set
//   beat_t            : one packed output beat {data, keep} at the default sizes
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_PACK  = 4;

    // Upper bound on lanes per beat that keep_from_count can describe.
    localparam int MAX_PACK  = 64;

    // Lane index width, $clog2(pack); never below one bit.
    function automatic int lane_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    // Mask with bits [count-1:0] set; callers truncate to their lane count.
    function automatic logic [MAX_PACK-1:0] keep_from_count(input int unsigned count);
        logic [MAX_PACK-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            mask[i] = (i < int'(count));
        end
        return mask;
    endfunction

    typedef struct packed {
        logic [DEF_DSIZE*DEF_PACK-1:0] data;
        logic [DEF_PACK-1:0]           keep;
    } beat_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Bundles the FIFO read port and the packed valid/ready output stream.
//   rdata/rempty/rinc           : FIFO read side (rinc driven by the packer)
//   flush                       : request to emit the current partial beat
//   out_data/out_keep/out_valid : packed beat towards the consumer
//   out_ready                   : consumer acceptance
//   word_cnt                    : number of beats transferred
// master = packer side, slave = FIFO + consumer side.
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int CNTW  = 16
);
    logic [DSIZE-1:0]      rdata;
    logic                  rempty;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNTW-1:0]       word_cnt;

    modport master (
        input  rdata, rempty, flush, out_ready,
        output rinc, out_data, out_keep, out_valid, word_cnt
    );

    modport slave (
        output rdata, rempty, flush, out_ready,
        input  rinc, out_data, out_keep, out_valid, word_cnt
    );
endinterface

// File: rtl/fifo_rd_outreg.sv
// -----------------------------------------------------------------------------
// fifo_rd_outreg
// One-entry valid/ready output register with a transfer counter.
//   clk, srst : clock and synchronous active-high reset
//   load_i    : capture data_i/keep_i (only asserted while free_o is high)
//   data_i    : beat to capture
//   keep_i    : lane mask to capture
//   ready_i   : consumer ready
//   data_o    : held beat
//   keep_o    : held lane mask
//   valid_o   : beat held
//   free_o    : register empty or draining this cycle (may load)
//   cnt_o     : transfers seen, wrapping
// -----------------------------------------------------------------------------
module fifo_rd_outreg
    import fifo_rd_pkg::*;
#(
    parameter int W    = 32,
    parameter int KW   = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            load_i,
    input  logic [W-1:0]    data_i,
    input  logic [KW-1:0]   keep_i,
    input  logic            ready_i,
    output logic [W-1:0]    data_o,
    output logic [KW-1:0]   keep_o,
    output logic            valid_o,
    output logic            free_o,
    output logic [CNTW-1:0] cnt_o
);

    logic [W-1:0]    data_q, data_d;
    logic [KW-1:0]   keep_q, keep_d;
    logic            valid_q, valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            xfer;

    always_comb begin
        xfer    = valid_q && ready_i;
        free_o  = !valid_q || xfer;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        // A load on the draining cycle replaces the beat back to back.
        if (load_i) begin
            data_d  = data_i;
            keep_d  = keep_i;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        cnt_d = cnt_q + CNTW'(xfer);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-domain consumer for an asynchronous FIFO: pops DSIZE-bit entries, packs
// PACK of them (lane 0 first, LSB aligned) into one beat and offers it on a
// valid/ready stream with a lane keep mask. A flush emits a partial beat.
//   rclk : read-domain clock
//   rrst : synchronous active-high reset
//   bus  : fifo_rd_packer_if.master (rdata, rempty, rinc, flush, out_data,
//          out_keep, out_valid, out_ready, word_cnt)
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int CNTW  = 16
) (
    input  logic               rclk,
    input  logic               rrst,
    fifo_rd_packer_if.master   bus
);

    localparam int            IW       = lane_w(PACK);
    localparam logic [IW-1:0] LAST_IDX = IW'(PACK - 1);

    logic [IW-1:0]         idx_q, idx_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  out_free;
    logic                  pop;
    logic                  full_beat;
    logic                  flush_req;
    logic                  emit_partial;
    logic                  drop_flush;
    logic                  load;
    logic [IW:0]           filled;
    logic [PACK-1:0]       beat_keep;
    logic [DSIZE*PACK-1:0] beat_data;

    always_comb begin
        // The last lane may only be popped when the beat has somewhere to go;
        // lanes below it are free to fill while the output is occupied.
        pop       = !rrst && !bus.rempty && ((idx_q != LAST_IDX) || out_free);
        full_beat = pop && (idx_q == LAST_IDX);

        // A flush acts on the cycle it arrives, not one cycle later.
        flush_req    = flush_pend_q || bus.flush;
        emit_partial = flush_req && out_free && !full_beat && (idx_q != '0);
        // Nothing accumulated and nothing arriving: the request is satisfied.
        drop_flush   = flush_req && out_free && (idx_q == '0) && !pop;
        load         = full_beat || emit_partial;

        // Lanes filled includes an entry popped on this same cycle.
        filled    = {1'b0, idx_q} + (IW + 1)'(pop);
        beat_keep = PACK'(keep_from_count(32'(filled)));

        idx_d = idx_q;
        if (load) begin
            idx_d = '0;
        end else if (pop) begin
            idx_d = idx_q + IW'(1);
        end
        flush_pend_d = flush_req && !load && !drop_flush;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Lane registers. The beat is assembled from the stored lanes plus the
    // entry being popped now, so a completing pop reaches the output register
    // on the same edge. Lanes outside the keep mask are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            logic [DSIZE-1:0] lane_q;
            logic             lane_hit;

            assign lane_hit = pop && (idx_q == IW'(gi));

            always_ff @(posedge rclk) begin
                if (rrst) begin
                    lane_q <= '0;
                end else if (lane_hit) begin
                    lane_q <= bus.rdata;
                end
            end

            assign beat_data[gi*DSIZE +: DSIZE] =
                !beat_keep[gi] ? '0 : (lane_hit ? bus.rdata : lane_q);
        end
    endgenerate

    fifo_rd_outreg #(
        .W    (DSIZE * PACK),
        .KW   (PACK),
        .CNTW (CNTW)
    ) u_outreg (
        .clk     (rclk),
        .srst    (rrst),
        .load_i  (load),
        .data_i  (beat_data),
        .keep_i  (beat_keep),
        .ready_i (bus.out_ready),
        .data_o  (bus.out_data),
        .keep_o  (bus.out_keep),
        .valid_o (bus.out_valid),
        .free_o  (out_free),
        .cnt_o   (bus.word_cnt)
    );

    assign bus.rinc = pop;

endmodule
